// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported RAM between an instruction fetcher (I) and a data port (D).
// One transaction in flight; D wins unless I has been passed over STARVE_LIMIT times in a row.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ins_valid_i,
  output logic              ins_ready_o,
  input  logic [ADDR_W-1:0] ins_addr_i,
  output logic              ins_rvalid_ro,
  output logic [31:0]       ins_rdata_ro,
  input  logic              jump_taken_i,
  input  logic              data_valid_i,
  output logic              data_ready_o,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic              data_write_i,
  input  logic [1:0]        data_width_i,
  input  logic [31:0]       data_wdata_i,
  output logic              data_rvalid_ro,
  output logic [31:0]       data_rdata_ro,
  output logic              mem_req_ro,
  output logic [ADDR_W-1:0] mem_addr_ro,
  output logic              mem_write_ro,
  output logic [1:0]        mem_width_ro,
  output logic [31:0]       mem_wdata_ro,
  input  logic              mem_ready_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i
);

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  localparam logic [3:0] CntMax = 4'(STARVE_LIMIT);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              kill_q, kill_d;
  logic              owner_q, owner_d;  // 1: D owns the transaction, 0: I
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_write_q, mem_write_d;
  logic [1:0]        mem_width_q, mem_width_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              ins_rvalid_q, ins_rvalid_d;
  logic [31:0]       ins_rdata_q, ins_rdata_d;
  logic              data_rvalid_q, data_rvalid_d;
  logic [31:0]       data_rdata_q, data_rdata_d;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    kill_d        = kill_q;
    owner_d       = owner_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    mem_write_d   = mem_write_q;
    mem_width_d   = mem_width_q;
    mem_wdata_d   = mem_wdata_q;
    ins_rvalid_d  = 1'b0;
    ins_rdata_d   = ins_rdata_q;
    data_rvalid_d = 1'b0;
    data_rdata_d  = data_rdata_q;
    data_ready_o  = 1'b0;
    ins_ready_o   = 1'b0;

    unique case (state_q)
      StIdle: begin
        kill_d       = 1'b0;
        data_ready_o = data_valid_i && !(ins_valid_i && !jump_taken_i && cnt_q == CntMax);
        ins_ready_o  = ins_valid_i && !jump_taken_i && !data_ready_o;
        if (data_ready_o) begin
          owner_d     = 1'b1;
          mem_addr_d  = data_addr_i;
          mem_write_d = data_write_i;
          mem_width_d = (data_width_i == 2'b11) ? 2'b10 : data_width_i;
          mem_wdata_d = data_write_i ? data_wdata_i : 32'h0;
          // Only count D wins that actually made I wait.
          if (ins_valid_i) begin
            cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 4'd1;
          end else begin
            cnt_d = 4'd0;
          end
          mem_req_d = 1'b1;
          state_d   = StReq;
        end else if (ins_ready_o) begin
          owner_d     = 1'b0;
          mem_addr_d  = ins_addr_i;
          mem_write_d = 1'b0;
          mem_width_d = 2'b10;
          mem_wdata_d = 32'h0;
          cnt_d       = 4'd0;
          mem_req_d   = 1'b1;
          state_d     = StReq;
        end
      end
      StReq: begin
        if (jump_taken_i && !owner_q) kill_d = 1'b1;
        if (mem_ready_i) begin
          mem_req_d = 1'b0;
          state_d   = StResp;
        end
      end
      StResp: begin
        if (jump_taken_i && !owner_q) kill_d = 1'b1;
        if (mem_rvalid_i) begin
          state_d = StIdle;
          kill_d  = 1'b0;
          if (owner_q) begin
            data_rvalid_d = 1'b1;
            data_rdata_d  = mem_write_q ? 32'h0 : mem_rdata_i;
          end else if (!kill_q && !jump_taken_i) begin
            // A jump on the completing edge also makes the fetch stale.
            ins_rvalid_d = 1'b1;
            ins_rdata_d  = mem_rdata_i;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= 4'd0;
      kill_q        <= 1'b0;
      owner_q       <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      mem_write_q   <= 1'b0;
      mem_width_q   <= 2'b00;
      mem_wdata_q   <= 32'h0;
      ins_rvalid_q  <= 1'b0;
      ins_rdata_q   <= 32'h0;
      data_rvalid_q <= 1'b0;
      data_rdata_q  <= 32'h0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      kill_q        <= kill_d;
      owner_q       <= owner_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      mem_write_q   <= mem_write_d;
      mem_width_q   <= mem_width_d;
      mem_wdata_q   <= mem_wdata_d;
      ins_rvalid_q  <= ins_rvalid_d;
      ins_rdata_q   <= ins_rdata_d;
      data_rvalid_q <= data_rvalid_d;
      data_rdata_q  <= data_rdata_d;
    end
  end

  assign mem_req_ro     = mem_req_q;
  assign mem_addr_ro    = mem_addr_q;
  assign mem_write_ro   = mem_write_q;
  assign mem_width_ro   = mem_width_q;
  assign mem_wdata_ro   = mem_wdata_q;
  assign ins_rvalid_ro  = ins_rvalid_q;
  assign ins_rdata_ro   = ins_rdata_q;
  assign data_rvalid_ro = data_rvalid_q;
  assign data_rdata_ro  = data_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; a tiny RAM responder answers with a programmable
// ready delay and a one-cycle read latency.
module tb_mem_port_arbiter;

  localparam int unsigned AddrW = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             ins_valid_i, ins_ready_o, ins_rvalid_ro, jump_taken_i;
  logic [AddrW-1:0] ins_addr_i, data_addr_i, mem_addr_ro;
  logic [31:0]      ins_rdata_ro, data_wdata_i, data_rdata_ro, mem_wdata_ro, mem_rdata_i;
  logic             data_valid_i, data_ready_o, data_write_i, data_rvalid_ro;
  logic [1:0]       data_width_i, mem_width_ro;
  logic             mem_req_ro, mem_write_ro, mem_ready_i, mem_rvalid_i;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          ram_delay = 0;
  logic [31:0] ram_rdata = 32'h0;
  int          wait_cnt;
  logic        rv_pend;

  mem_port_arbiter #(.STARVE_LIMIT(4), .ADDR_W(AddrW)) dut (
    .clk(clk), .rst(rst),
    .ins_valid_i(ins_valid_i), .ins_ready_o(ins_ready_o), .ins_addr_i(ins_addr_i),
    .ins_rvalid_ro(ins_rvalid_ro), .ins_rdata_ro(ins_rdata_ro), .jump_taken_i(jump_taken_i),
    .data_valid_i(data_valid_i), .data_ready_o(data_ready_o), .data_addr_i(data_addr_i),
    .data_write_i(data_write_i), .data_width_i(data_width_i), .data_wdata_i(data_wdata_i),
    .data_rvalid_ro(data_rvalid_ro), .data_rdata_ro(data_rdata_ro),
    .mem_req_ro(mem_req_ro), .mem_addr_ro(mem_addr_ro), .mem_write_ro(mem_write_ro),
    .mem_width_ro(mem_width_ro), .mem_wdata_ro(mem_wdata_ro), .mem_ready_i(mem_ready_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  // RAM model: ready after ram_delay waiting cycles, response on the following cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= 0;
      rv_pend  <= 1'b0;
    end else begin
      rv_pend  <= mem_req_ro && mem_ready_i;
      wait_cnt <= (mem_req_ro && !mem_ready_i) ? wait_cnt + 1 : 0;
    end
  end
  assign mem_ready_i  = mem_req_ro && (wait_cnt >= ram_delay);
  assign mem_rvalid_i = rv_pend;
  assign mem_rdata_i  = rv_pend ? ram_rdata : 32'hDEAD_BEEF;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   grants[6];
    int   ng;
    logic seen;

    rst = 1'b1;
    ins_valid_i = 1'b0; ins_addr_i = '0; jump_taken_i = 1'b0;
    data_valid_i = 1'b0; data_addr_i = '0; data_write_i = 1'b0;
    data_width_i = 2'b10; data_wdata_i = 32'h0;
    tick(); tick();
    check_eq("rst_mem_req", 32'(mem_req_ro), 32'd0);
    check_eq("rst_ins_rvalid", 32'(ins_rvalid_ro), 32'd0);
    check_eq("rst_data_rvalid", 32'(data_rvalid_ro), 32'd0);
    check_eq("rst_mem_addr", mem_addr_ro, 32'd0);
    rst = 1'b0;
    tick();

    // I-only fetch, minimum turnaround
    ram_delay = 0; ram_rdata = 32'h0000_0013;
    ins_valid_i = 1'b1; ins_addr_i = 32'h100;
    #1 check_eq("i_ready", 32'(ins_ready_o), 32'd1);
    check_eq("i_dready", 32'(data_ready_o), 32'd0);
    tick(); ins_valid_i = 1'b0;
    check_eq("i_req", 32'(mem_req_ro), 32'd1);
    check_eq("i_addr", mem_addr_ro, 32'h100);
    check_eq("i_width", 32'(mem_width_ro), 32'd2);
    check_eq("i_write", 32'(mem_write_ro), 32'd0);
    tick();
    check_eq("i_req_drop", 32'(mem_req_ro), 32'd0);
    check_eq("i_rvalid_early", 32'(ins_rvalid_ro), 32'd0);
    tick();
    check_eq("i_rvalid", 32'(ins_rvalid_ro), 32'd1);
    check_eq("i_rdata", ins_rdata_ro, 32'h13);
    check_eq("i_no_drvalid", 32'(data_rvalid_ro), 32'd0);
    tick();
    check_eq("i_rvalid_pulse", 32'(ins_rvalid_ro), 32'd0);

    // Simultaneous I and D: D first, I accepted in D's response-pulse cycle
    ram_rdata = 32'h0000_0055;
    ins_valid_i = 1'b1; ins_addr_i = 32'h104;
    data_valid_i = 1'b1; data_addr_i = 32'h2000; data_write_i = 1'b0; data_width_i = 2'b10;
    #1 check_eq("pri_dready", 32'(data_ready_o), 32'd1);
    check_eq("pri_iready", 32'(ins_ready_o), 32'd0);
    tick(); data_valid_i = 1'b0;
    check_eq("pri_daddr", mem_addr_ro, 32'h2000);
    check_eq("pri_iready_busy", 32'(ins_ready_o), 32'd0);
    tick(); tick();
    check_eq("pri_drvalid", 32'(data_rvalid_ro), 32'd1);
    check_eq("pri_drdata", data_rdata_ro, 32'h55);
    check_eq("pri_iready_pulse", 32'(ins_ready_o), 32'd1);
    ram_rdata = 32'h0000_0066;
    tick(); ins_valid_i = 1'b0;
    check_eq("pri_iaddr", mem_addr_ro, 32'h104);
    tick(); tick();
    check_eq("pri_irvalid", 32'(ins_rvalid_ro), 32'd1);
    check_eq("pri_irdata", ins_rdata_ro, 32'h66);

    // Starvation guard: 4 D grants, then I, then D again
    ins_valid_i = 1'b1; data_valid_i = 1'b1; ins_addr_i = 32'h108; data_addr_i = 32'h2010;
    ng = 0;
    for (int c = 0; c < 40 && ng < 6; c++) begin
      #1;
      if (data_ready_o) begin grants[ng] = 1; ng++; end
      else if (ins_ready_o) begin grants[ng] = 2; ng++; end
      if (ng == 6) begin ins_valid_i = 1'b0; data_valid_i = 1'b0; end
      tick();
    end
    check_eq("starve_count", 32'(ng), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check_eq($sformatf("starve_grant%0d", i), 32'(grants[i]), (i == 4) ? 32'd2 : 32'd1);
    end
    tick(); tick(); tick();

    // Jump on the completing RESP cycle
    ram_rdata = 32'h77;
    ins_valid_i = 1'b1; ins_addr_i = 32'h200;
    #1 check_eq("jk_iready", 32'(ins_ready_o), 32'd1);
    tick(); ins_valid_i = 1'b0;
    tick();
    jump_taken_i = 1'b1;
    tick(); jump_taken_i = 1'b0;
    check_eq("jk_rvalid", 32'(ins_rvalid_ro), 32'd0);
    // Jump during REQ with a slow RAM
    ram_delay = 2;
    ins_valid_i = 1'b1; ins_addr_i = 32'h204;
    tick(); ins_valid_i = 1'b0;
    jump_taken_i = 1'b1;
    tick(); jump_taken_i = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      seen = seen | ins_rvalid_ro;
      tick();
    end
    check_eq("jk_req_rvalid", 32'(seen), 32'd0);
    ins_valid_i = 1'b1; jump_taken_i = 1'b1;
    #1 check_eq("jk_idle_block", 32'(ins_ready_o), 32'd0);
    jump_taken_i = 1'b0;
    #1 check_eq("jk_idle_ok", 32'(ins_ready_o), 32'd1);
    ins_valid_i = 1'b0;
    tick();

    // Store held through 3 not-ready cycles
    ram_delay = 3; ram_rdata = 32'h1234;
    data_valid_i = 1'b1; data_write_i = 1'b1; data_addr_i = 32'h2004;
    data_width_i = 2'b00; data_wdata_i = 32'hAB;
    tick();
    data_valid_i = 1'b0; data_addr_i = 32'hFFFF; data_wdata_i = 32'h0; data_write_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("st_hold%0d", i),
               {mem_req_ro, mem_write_ro, mem_width_ro, mem_wdata_ro[27:0]},
               {1'b1, 1'b1, 2'b00, 28'hAB});
      check_eq($sformatf("st_addr%0d", i), mem_addr_ro, 32'h2004);
      tick();
    end
    tick(); tick();
    check_eq("st_ack", 32'(data_rvalid_ro), 32'd1);
    check_eq("st_rdata", data_rdata_ro, 32'h0);
    tick();

    // Reset in REQ
    ram_delay = 5;
    ins_valid_i = 1'b1; ins_addr_i = 32'h300;
    tick(); ins_valid_i = 1'b0;
    check_eq("rr_req", 32'(mem_req_ro), 32'd1);
    #2 rst = 1'b1;
    #1 check_eq("rr_req_drop", 32'(mem_req_ro), 32'd0);
    tick(); rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      seen = seen | ins_rvalid_ro | data_rvalid_ro;
      tick();
    end
    check_eq("rr_no_rvalid", 32'(seen), 32'd0);
    ram_delay = 0; ram_rdata = 32'h99;
    ins_valid_i = 1'b1; ins_addr_i = 32'h304;
    #1 check_eq("rr_iready", 32'(ins_ready_o), 32'd1);
    tick(); ins_valid_i = 1'b0;
    check_eq("rr_addr", mem_addr_ro, 32'h304);
    tick(); tick();
    check_eq("rr_rvalid", 32'(ins_rvalid_ro), 32'd1);
    check_eq("rr_rdata", ins_rdata_ro, 32'h99);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified memory port between instruction-memory stage (read-only requester I) and execute/data-memory stage (read/write requester D).
- Sits between pipeline stages and the single-ported RAM.
- One outstanding transaction at a time; D has priority, with a starvation guard for I.
- Drops stale instruction responses on a taken jump.

Parameters:
- STARVE_LIMIT, 4, consecutive D grants allowed while I is waiting before I is forced to win (1..15).
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- ins_valid_i  in  1  I request valid
- ins_ready_o  out  1  I request accepted this cycle (combinational)
- ins_addr_i  in  ADDR_W  I fetch address
- ins_rvalid_ro  out  1  I read data valid, one-cycle pulse
- ins_rdata_ro  out  32  I read data
- jump_taken_i  in  1  redirect; kills in-flight/pending I work
- data_valid_i  in  1  D request valid
- data_ready_o  out  1  D request accepted this cycle (combinational)
- data_addr_i  in  ADDR_W  D address
- data_write_i  in  1  1 = store, 0 = load
- data_width_i  in  2  00 byte, 01 half, 10 word, 11 treated as word
- data_wdata_i  in  32  store data
- data_rvalid_ro  out  1  D load data / store ack, one-cycle pulse
- data_rdata_ro  out  32  D load data (0 on store ack)
- mem_req_ro  out  1  request to RAM
- mem_addr_ro  out  ADDR_W  latched address
- mem_write_ro  out  1  latched write
- mem_width_ro  out  2  latched width (10 for I)
- mem_wdata_ro  out  32  latched store data (0 for I)
- mem_ready_i  in  1  RAM accepts request
- mem_rvalid_i  in  1  RAM response / write ack
- mem_rdata_i  in  32  RAM read data

Behaviour:
- Reset (async, immediate):
  - state = IDLE.
  - All _ro outputs = 0.
  - Starvation counter = 0; kill flag = 0; owner = I.
- FSM: IDLE -> REQ -> RESP -> IDLE.
- IDLE:
  - data_ready_o = data_valid_i && !(ins_valid_i && !jump_taken_i && cnt == STARVE_LIMIT).
  - ins_ready_o = ins_valid_i && !jump_taken_i && !data_ready_o.
  - Both ready outputs are 0 outside IDLE.
  - On accept: latch addr/write/width/wdata and owner; go to REQ; mem_req_ro = 1 from the next cycle.
- REQ:
  - Hold mem_req_ro and all mem_* outputs stable until mem_ready_i = 1.
  - On that edge: clear mem_req_ro and go to RESP.
- RESP:
  - Wait for mem_rvalid_i.
  - On that edge: register mem_rdata_i into the owner's rdata_ro and pulse the owner's rvalid_ro for exactly one cycle (the next cycle).
  - Return to IDLE on the same edge, so a new accept is possible in the pulse cycle.
- Minimum turnaround: accept at N; mem_req_ro at N+1; if mem_ready_i at N+1 and mem_rvalid_i at N+2, rvalid_ro at N+3 and next accept at N+3.
- Starvation counter:
  - On a D grant with ins_valid_i = 1: cnt++ (saturating at STARVE_LIMIT).
  - On an I grant, or a D grant with ins_valid_i = 0: cnt = 0.
- Jump kill:
  - jump_taken_i while owner = I in REQ or RESP sets kill.
  - The transaction still completes on the memory side, but ins_rvalid_ro is suppressed.
  - kill clears on return to IDLE.
  - jump_taken_i in IDLE blocks the I accept that cycle.
  - D transactions are never affected.
- Store: data_rvalid_ro pulses on write ack with data_rdata_ro = 0.
- mem_rvalid_i outside RESP is ignored.
- mem_ready_i outside REQ is ignored.
- Reset mid-transaction: all state is abandoned and no rvalid pulse is issued.

Test Plan:
- I only: ins_addr_i = 0x100; RAM ready at N+1, rvalid at N+2 with rdata 0x00000013 -> ins_rvalid_ro = 1 at N+3 with 0x00000013; mem_width_ro = 10; mem_write_ro = 0.
- Simultaneous I and D (load 0x2000) in IDLE -> D accepted first; I accepted in the cycle data_rvalid_ro pulses.
- Starvation: ins_valid_i held, data_valid_i held, STARVE_LIMIT = 4 -> exactly 4 D grants, then an I grant, then the counter restarts.
- Jump kill: I accepted, jump_taken_i pulsed in RESP -> RAM completes, ins_rvalid_ro stays 0, FSM back in IDLE; with jump_taken_i = 1 in IDLE, ins_ready_o = 0.
- Store: D write, addr 0x2004, width 00, wdata 0xAB -> mem_* fields held stable while mem_ready_i is held 0 for 3 cycles; data_rvalid_ro pulses with data_rdata_ro = 0.
- Reset asserted in REQ -> mem_req_ro drops immediately; no rvalid pulse; next accept works normally.
